// File: rtl/tod_pkg.sv
// Shared definitions for the time-of-day keeper: sync-state encoding, packed BCD
// time layout and the BCD validation / 12-hour conversion helpers.
package tod_pkg;

  localparam logic [1:0] SYNC_ACQUIRE  = 2'd0;
  localparam logic [1:0] SYNC_LOCKED   = 2'd1;
  localparam logic [1:0] SYNC_HOLDOVER = 2'd2;
  localparam logic [1:0] SYNC_FREE_RUN = 2'd3;

  typedef enum logic [1:0] {
    ACQUIRE  = SYNC_ACQUIRE,
    LOCKED   = SYNC_LOCKED,
    HOLDOVER = SYNC_HOLDOVER,
    FREE_RUN = SYNC_FREE_RUN
  } sync_e;

  localparam int TIME_W    = 20;
  localparam int SEC1_LSB  = 0;
  localparam int SEC1_W    = 4;
  localparam int SEC2_LSB  = 4;
  localparam int SEC2_W    = 3;
  localparam int MIN1_LSB  = 7;
  localparam int MIN1_W    = 4;
  localparam int MIN2_LSB  = 11;
  localparam int MIN2_W    = 3;
  localparam int HOUR1_LSB = 14;
  localparam int HOUR1_W   = 4;
  localparam int HOUR2_LSB = 18;
  localparam int HOUR2_W   = 2;
  localparam int HOUR_LSB  = HOUR1_LSB;
  localparam int HOUR_W    = HOUR1_W + HOUR2_W;

  function automatic logic tod_valid(input logic [TIME_W-1:0] t, input logic v);
    logic [3:0] s1, m1, h1;
    logic [2:0] s2, m2;
    logic [1:0] h2;
    s1 = t[SEC1_LSB +: SEC1_W];
    s2 = t[SEC2_LSB +: SEC2_W];
    m1 = t[MIN1_LSB +: MIN1_W];
    m2 = t[MIN2_LSB +: MIN2_W];
    h1 = t[HOUR1_LSB +: HOUR1_W];
    h2 = t[HOUR2_LSB +: HOUR2_W];
    return v && (s1 <= 4'd9) && (s2 <= 3'd5) && (m1 <= 4'd9) && (m2 <= 3'd5) &&
           (h1 <= 4'd9) && (h2 <= 2'd2) && !((h2 == 2'd2) && (h1 > 4'd3));
  endfunction

  function automatic logic [4:0] hour_bcd_to_bin(input logic [HOUR_W-1:0] h);
    return 5'(h[5:4]) * 5'd10 + 5'(h[3:0]);
  endfunction

  function automatic logic [HOUR_W-1:0] hour_bin_to_bcd(input logic [4:0] b);
    if (b >= 5'd20)      return {2'd2, 4'(b - 5'd20)};
    else if (b >= 5'd10) return {2'd1, 4'(b - 5'd10)};
    else                 return {2'd0, b[3:0]};
  endfunction

  // Returns {pm, hour12_bcd}; midnight renders as 12 AM, noon as 12 PM.
  function automatic logic [HOUR_W:0] bcd24_to_12(input logic [HOUR_W-1:0] h24);
    logic [4:0] hb;
    logic [4:0] h12;
    hb = hour_bcd_to_bin(h24);
    if (hb == 5'd0)       h12 = 5'd12;
    else if (hb > 5'd12)  h12 = hb - 5'd12;
    else                  h12 = hb;
    return {(hb >= 5'd12), hour_bin_to_bcd(h12)};
  endfunction

endpackage

// File: rtl/tod_incr.sv
// Combinational next-second function on packed 24-hour BCD time; 23:59:59 wraps
// to 00:00:00.
module tod_incr
  import tod_pkg::*;
(
  input  logic [TIME_W-1:0] time_i,
  output logic [TIME_W-1:0] time_o
);

  logic [3:0] s1, m1, h1;
  logic [2:0] s2, m2;
  logic [1:0] h2;

  always_comb begin
    s1 = time_i[SEC1_LSB +: SEC1_W];
    s2 = time_i[SEC2_LSB +: SEC2_W];
    m1 = time_i[MIN1_LSB +: MIN1_W];
    m2 = time_i[MIN2_LSB +: MIN2_W];
    h1 = time_i[HOUR1_LSB +: HOUR1_W];
    h2 = time_i[HOUR2_LSB +: HOUR2_W];
    // Each digit rolls only when every lower digit is at its maximum.
    if (s1 != 4'd9) s1 = s1 + 4'd1;
    else begin
      s1 = 4'd0;
      if (s2 != 3'd5) s2 = s2 + 3'd1;
      else begin
        s2 = 3'd0;
        if (m1 != 4'd9) m1 = m1 + 4'd1;
        else begin
          m1 = 4'd0;
          if (m2 != 3'd5) m2 = m2 + 3'd1;
          else begin
            m2 = 3'd0;
            if ((h2 == 2'd2) && (h1 == 4'd3)) begin
              h2 = 2'd0;
              h1 = 4'd0;
            end else if (h1 == 4'd9) begin
              h1 = 4'd0;
              h2 = h2 + 2'd1;
            end else begin
              h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    time_o = {h2, h1, m2, m1, s2, s1};
  end

endmodule

// File: rtl/tod_keeper.sv
// GPS-disciplined time-of-day keeper with sync-quality tracking and 12/24h display.
// Optional TZ_OFFSET_EN adds a signed display-hour offset input tz_hours.
module tod_keeper
  import tod_pkg::*;
#(
  parameter int LOCK_COUNT   = 3,
  parameter int HOLDOVER_MAX = 3600,
  parameter int RESET_HOUR   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pps_in,
  input  logic [TIME_W-1:0] time_in,
  input  logic              time_valid_in,
  input  logic              backup_sec,
  input  logic              mode_24h,
`ifdef TZ_OFFSET_EN
  input  logic [4:0]        tz_hours,
`endif
  output logic [TIME_W-1:0] time_out,
  output logic              pm,
  output logic [1:0]        sync_state,
  output logic [15:0]       holdover_secs,
  output logic              sec_tick,
  output logic              load_err
);

  localparam logic [HOUR_W-1:0] RESET_HOUR_BCD = hour_bin_to_bcd(5'(RESET_HOUR));
  localparam logic [TIME_W-1:0] RESET_TIME     = {RESET_HOUR_BCD, 14'd0};
  localparam logic              RESET_PM       = (RESET_HOUR >= 12);

  sync_e             state_q, state_d;
  logic [3:0]        lock_q, lock_d, lock_inc;
  logic [15:0]       hold_q, hold_d, hold_inc;
  logic [TIME_W-1:0] time_q, time_d, time_inc;
  logic              upd_q, load_err_q;
  logic [TIME_W-1:0] time_out_q, render_d;
  logic              pm_q, pm_d, sec_tick_q;
  logic              upd, pps_ok;

  tod_incr u_incr (
    .time_i (time_q),
    .time_o (time_inc)
  );

  assign upd      = pps_in | backup_sec;
  assign pps_ok   = pps_in & tod_valid(time_in, time_valid_in);
  assign lock_inc = lock_q + 4'd1;
  assign hold_inc = hold_q + 16'd1;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    hold_d  = hold_q;
    time_d  = time_q;
    if (pps_ok)   time_d = time_in;
    else if (upd) time_d = time_inc;
    if (upd) begin
      unique case (state_q)
        ACQUIRE: begin
          if (!pps_ok) lock_d = 4'd0;
          else if (lock_inc >= 4'(LOCK_COUNT)) begin
            state_d = LOCKED;
            lock_d  = 4'd0;
          end else lock_d = lock_inc;
        end
        LOCKED: begin
          if (!pps_ok) begin
            if (HOLDOVER_MAX <= 1) begin
              state_d = FREE_RUN;
              hold_d  = 16'(HOLDOVER_MAX);
            end else begin
              state_d = HOLDOVER;
              hold_d  = 16'd1;
            end
          end
        end
        HOLDOVER: begin
          if (pps_ok) begin
            state_d = LOCKED;
            hold_d  = 16'd0;
          end else begin
            hold_d = hold_inc;
            if (hold_inc >= 16'(HOLDOVER_MAX)) state_d = FREE_RUN;
          end
        end
        FREE_RUN: begin
          if (pps_ok) begin
            state_d = ACQUIRE;
            lock_d  = 4'd1;
            hold_d  = 16'd0;
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // Display rendering of the current internal UTC time (optionally zone-shifted).
  logic [4:0]        hb_utc, hb_disp;
  logic [HOUR_W-1:0] h_bcd;
  logic [HOUR_W:0]   h12;

  always_comb begin
    hb_utc = hour_bcd_to_bin(time_q[HOUR_LSB +: HOUR_W]);
    hb_disp = hb_utc;
`ifdef TZ_OFFSET_EN
    begin
      logic signed [4:0] tz_s;
      logic signed [6:0] hs;
      tz_s = $signed(tz_hours);
      hs   = $signed({2'b00, hb_utc});
      if ((tz_s >= -5'sd12) && (tz_s <= 5'sd14)) hs = hs + 7'(tz_s);
      if (hs < 7'sd0)        hs = hs + 7'sd24;
      else if (hs >= 7'sd24) hs = hs - 7'sd24;
      hb_disp = hs[4:0];
    end
`endif
    h_bcd = hour_bin_to_bcd(hb_disp);
    h12   = bcd24_to_12(h_bcd);
    pm_d  = (hb_disp >= 5'd12);
    if (mode_24h) render_d = {h_bcd, time_q[13:0]};
    else          render_d = {h12[HOUR_W-1:0], time_q[13:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ACQUIRE;
      lock_q     <= 4'd0;
      hold_q     <= 16'd0;
      time_q     <= RESET_TIME;
      upd_q      <= 1'b0;
      load_err_q <= 1'b0;
      time_out_q <= RESET_TIME;
      pm_q       <= RESET_PM;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      hold_q     <= hold_d;
      time_q     <= time_d;
      upd_q      <= upd;
      load_err_q <= pps_in & ~pps_ok;
      time_out_q <= render_d;
      pm_q       <= pm_d;
      sec_tick_q <= upd_q;
    end
  end

  assign time_out      = time_out_q;
  assign pm            = pm_q;
  assign sync_state    = state_q;
  assign holdover_secs = hold_q;
  assign sec_tick      = sec_tick_q;
  assign load_err      = load_err_q;

endmodule

// File: tb/tb_tod_keeper.sv
// Directed self-checking bench for tod_keeper (HOLDOVER_MAX reduced to 4).
`timescale 1ns/1ps
module tb_tod_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        pps_in;
  logic [19:0] time_in;
  logic        time_valid_in;
  logic        backup_sec;
  logic        mode_24h;
`ifdef TZ_OFFSET_EN
  logic [4:0]  tz_hours;
`endif
  logic [19:0] time_out;
  logic        pm;
  logic [1:0]  sync_state;
  logic [15:0] holdover_secs;
  logic        sec_tick;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  tod_keeper #(.LOCK_COUNT(3), .HOLDOVER_MAX(4), .RESET_HOUR(12)) dut (
    .clk           (clk),
    .reset         (reset),
    .pps_in        (pps_in),
    .time_in       (time_in),
    .time_valid_in (time_valid_in),
    .backup_sec    (backup_sec),
    .mode_24h      (mode_24h),
`ifdef TZ_OFFSET_EN
    .tz_hours      (tz_hours),
`endif
    .time_out      (time_out),
    .pm            (pm),
    .sync_state    (sync_state),
    .holdover_secs (holdover_secs),
    .sec_tick      (sec_tick),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] tp(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic p, input logic b, input logic [19:0] t, input logic v);
    pps_in = p; backup_sec = b; time_in = t; time_valid_in = v;
    @(posedge clk); #1;
    pps_in = 1'b0; backup_sec = 1'b0; time_valid_in = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; pps_in = 1'b0; backup_sec = 1'b0; time_in = '0;
    time_valid_in = 1'b0; mode_24h = 1'b1;
`ifdef TZ_OFFSET_EN
    tz_hours = 5'd0;
`endif
    repeat (2) @(posedge clk); #1;
    check("rst_time", time_out, tp(12, 0, 0));
    check("rst_pm", pm, 1);
    check("rst_state", sync_state, 0);
    check("rst_hold", holdover_secs, 0);
    check("rst_tick", sec_tick, 0);
    check("rst_lerr", load_err, 0);
    reset = 1'b1;
    idle();

    // Acquire lock with three consecutive valid PPS loads
    step(1, 0, tp(10, 0, 0), 1);  check("acq1_state", sync_state, 0);
    step(1, 0, tp(10, 0, 1), 1);  check("acq2_state", sync_state, 0);
    step(1, 0, tp(10, 0, 2), 1);  check("acq3_state", sync_state, 1);
    idle();
    check("lock_time", time_out, tp(10, 0, 2));
    check("lock_tick", sec_tick, 1);
    check("lock_pm", pm, 0);
    idle();
    check("tick_clear", sec_tick, 0);

    // Midnight wrap on a backup tick enters holdover
    step(1, 0, tp(23, 59, 59), 1);  check("wrap_pre_state", sync_state, 1);
    step(0, 1, '0, 0);
    check("wrap_state", sync_state, 2);
    check("wrap_hold", holdover_secs, 1);
    idle();
    check("wrap_time24", time_out, tp(0, 0, 0));
    check("wrap_pm24", pm, 0);
    mode_24h = 1'b0;
    idle();
    check("wrap_time12", time_out, tp(12, 0, 0));
    check("wrap_pm12", pm, 0);
    check("wrap_notick", sec_tick, 0);
    mode_24h = 1'b1;

    // Holdover expiry into free-run, then recovery to acquire
    step(1, 0, tp(1, 0, 0), 1);
    check("relock_state", sync_state, 1);
    check("relock_hold", holdover_secs, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    check("ho3_state", sync_state, 2);
    check("ho3_hold", holdover_secs, 3);
    step(0, 1, '0, 0);
    check("fr_state", sync_state, 3);
    check("fr_hold", holdover_secs, 4);
    idle();
    check("fr_time", time_out, tp(1, 0, 4));
    step(0, 1, '0, 0);
    check("fr_sat_hold", holdover_secs, 4);
    check("fr_sat_state", sync_state, 3);
    step(1, 0, tp(6, 7, 8), 1);
    check("fr_acq_state", sync_state, 0);
    check("fr_acq_hold", holdover_secs, 0);
    idle();
    check("fr_acq_time", time_out, tp(6, 7, 8));

    // Rejected loads: out-of-range hour, deasserted valid, bad minute digit
    step(1, 0, tp(8, 15, 29), 1);  check("acq_l2_state", sync_state, 0);
    step(1, 0, tp(8, 15, 30), 1);  check("acq_l3_state", sync_state, 1);
    step(1, 0, tp(24, 0, 0), 1);
    check("bad24_lerr", load_err, 1);
    check("bad24_state", sync_state, 2);
    check("bad24_hold", holdover_secs, 1);
    idle();
    check("bad24_time", time_out, tp(8, 15, 31));
    check("bad24_lerr_clr", load_err, 0);
    check("bad24_tick", sec_tick, 1);
    step(1, 0, tp(8, 0, 0), 1);  check("nv_pre_state", sync_state, 1);
    step(1, 0, tp(9, 0, 0), 0);
    check("nv_lerr", load_err, 1);
    check("nv_state", sync_state, 2);
    idle();
    check("nv_time", time_out, tp(8, 0, 1));
    step(1, 0, tp(8, 60, 0), 1);
    check("badmin_lerr", load_err, 1);
    check("badmin_hold", holdover_secs, 2);

    // Simultaneous PPS and backup: PPS wins, no extra increment
    step(1, 1, tp(5, 5, 5), 1);
    check("both_state", sync_state, 1);
    check("both_lerr", load_err, 0);
    idle();
    check("both_time", time_out, tp(5, 5, 5));

    // Mode toggle without an update re-renders only
    step(1, 0, tp(17, 0, 0), 1);
    idle(); idle();
    check("pm24_time", time_out, tp(17, 0, 0));
    check("pm24_pm", pm, 1);
    mode_24h = 1'b0;
    idle();
    check("pm12_time", time_out, tp(5, 0, 0));
    check("pm12_pm", pm, 1);
    check("pm12_notick", sec_tick, 0);

    // Asynchronous reset mid-operation
    #2 reset = 1'b0;
    #1;
    check("mid_rst_state", sync_state, 0);
    check("mid_rst_time", time_out, tp(12, 0, 0));
    check("mid_rst_pm", pm, 1);
    idle();
    reset = 1'b1;
    step(0, 1, '0, 0);
    check("post_rst_state", sync_state, 0);
    idle();
    check("post_rst_time12", time_out, tp(12, 0, 1));
    check("post_rst_pm", pm, 1);

`ifdef TZ_OFFSET_EN
    tz_hours = 5'b11011;  // -5
    mode_24h = 1'b1;
    step(1, 0, tp(2, 30, 0), 1);
    idle();
    check("tz_time24", time_out, tp(21, 30, 0));
    check("tz_pm24", pm, 1);
    mode_24h = 1'b0;
    idle();
    check("tz_time12", time_out, tp(9, 30, 0));
    check("tz_pm12", pm, 1);
    tz_hours = 5'd15;  // out of range -> treated as 0
    mode_24h = 1'b1;
    idle();
    check("tz_oor_time", time_out, tp(2, 30, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tod_keeper.md
Name: tod_keeper

Overview:
Parametrised GPS-disciplined time-of-day keeper. Holds UTC time internally in 24-hour BCD. Loads validated GPS time on each single-cycle PPS pulse and free-wheels on the backup-second tick when PPS is absent. Tracks sync quality through an acquire/locked/holdover/free-run state machine and presents time in 12- or 24-hour display form to the display/driver stage.

Parameters:
LOCK_COUNT, 3, consecutive valid PPS loads needed to move ACQUIRE->LOCKED (1..15)
HOLDOVER_MAX, 3600, backup seconds allowed in HOLDOVER before FREE_RUN (1..65535)
RESET_HOUR, 12, 24-hour value loaded at reset (0..23)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pps_in  in  1  single-cycle PPS pulse
time_in  in  20  GPS UTC time, packed {hour_2[1:0],hour_1[3:0],min_2[2:0],min_1[3:0],sec_2[2:0],sec_1[3:0]}, 24-hour BCD
time_valid_in  in  1  time_in qualified; sampled only on pps_in cycles
backup_sec  in  1  single-cycle tick from ms counter; upstream asserts it only when PPS is missing
mode_24h  in  1  1 = 24-hour display, 0 = 12-hour display
time_out  out  20  display time, same packing as time_in
pm  out  1  PM flag; valid in both modes (hour >= 12)
sync_state  out  2  0 ACQUIRE, 1 LOCKED, 2 HOLDOVER, 3 FREE_RUN
holdover_secs  out  16  seconds spent in current HOLDOVER; saturates
sec_tick  out  1  one-cycle pulse coincident with each time_out update
load_err  out  1  one-cycle pulse when a PPS load is rejected

Behaviour:
- Reset (async, reset==0):
  - internal time = RESET_HOUR:00:00
  - time_out = 12:00:00 encoding (RESET_HOUR=12), pm=1
  - sync_state=ACQUIRE, lock_cnt=0, holdover_secs=0, sec_tick=0, load_err=0
- Valid load requires all of: time_valid_in=1; sec_1,min_1<=9; sec_2,min_2<=5; hour_2<=2; hour_1<=9; hour_2==2 implies hour_1<=3.
- Update cycle is any cycle with pps_in or backup_sec high.
  - pps_in has priority when both are high; backup_sec is ignored that cycle.
  - Valid PPS: internal time <= time_in.
  - Invalid PPS: load_err pulse; internal time increments by one second, same as a backup tick.
- Increment carries sec->min->hour. 23:59:59 wraps to 00:00:00.
- State machine transitions, evaluated on update cycles only:
  - ACQUIRE:
    - valid PPS: lock_cnt++; on reaching LOCK_COUNT -> LOCKED and lock_cnt cleared.
    - invalid PPS or backup: lock_cnt=0.
  - LOCKED:
    - valid PPS: stay.
    - backup or invalid PPS: -> HOLDOVER, holdover_secs=1.
  - HOLDOVER:
    - backup or invalid PPS: holdover_secs++; on reaching HOLDOVER_MAX -> FREE_RUN (holdover_secs holds HOLDOVER_MAX).
    - valid PPS: -> LOCKED, holdover_secs=0.
  - FREE_RUN:
    - backup: increment time only.
    - valid PPS: -> ACQUIRE, lock_cnt=1; holdover_secs=0.
- Output stage is registered: time_out/pm/sec_tick reflect the internal update 1 cycle later.
  - 12-hour conversion: 00->12 AM, 01-11 AM unchanged, 12->12 PM, 13-23 -> 01-11 PM.
- mode_24h change with no update: time_out re-renders on the next cycle, sec_tick stays 0, internal time untouched.
- Reset asserted mid-operation: all state returns to reset values immediately. The first update after release uses reset values.

Optional Feature:
TZ_OFFSET_EN
- Defined: adds port tz_hours (in, 5, signed, -12..+14).
  - Offset is added to the internal UTC hour in the output stage, mod 24, before 12-hour conversion.
  - Out-of-range values are treated as 0.
  - Internal time, validation and state machine stay UTC.
  - Output latency is still 1 cycle.
- Undefined: port absent; output is UTC.

Decomposition:
- Package tod_pkg holds:
  - sync_state encoding localparams
  - packed time field offsets/widths
  - function tod_valid()
  - function bcd24_to_12()
- Sub-module tod_incr: combinational next-second function, 20-bit in -> 20-bit out, 24-hour wrap.
  - Reused by the future date/alarm blocks.

Test Plan:
- Release reset, 3 valid PPS with time_in 10:00:00/01/02, mode_24h=1 -> time_out 10:00:02 one cycle after third PPS; sync_state=LOCKED after third.
- In LOCKED at 23:59:59, backup_sec -> time_out 00:00:00, sync_state=HOLDOVER, holdover_secs=1; with mode_24h=0 -> 12:00:00, pm=0.
- HOLDOVER_MAX=4, four backup ticks from LOCKED -> FREE_RUN, holdover_secs=4. Then valid PPS -> ACQUIRE, time loaded.
- PPS with time_in 24:00:00 (or time_valid_in=0) while LOCKED at 08:15:30 -> load_err pulse, time_out 08:15:31, sync_state=HOLDOVER.
- pps_in and backup_sec in the same cycle, time_in 05:05:05 -> time_out 05:05:05 (no extra increment); mode toggle to 12h at 17:00:00 -> 05:00:00, pm=1, no sec_tick.
- TZ_OFFSET_EN, tz_hours=-5, UTC 02:30:00 -> time_out 21:30:00 (24h) / 09:30:00 pm=1 (12h).
